// File: rtl/bus_arb_pkg.sv
// Shared types, constants and helpers for the terminal bus arbiter family.
package bus_arb_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        StIdle,
        StPop,
        StDeliver
    } arb_state_e;

    // Arbitration mode select values for the priority encoder.
    localparam logic ARB_RR    = 1'b0;
    localparam logic ARB_FIXED = 1'b1;

    // Widest packet / destination the helper below can handle.
    localparam int unsigned PKT_MAX_W  = 64;
    localparam int unsigned PKT_IDX_W  = $clog2(PKT_MAX_W);
    localparam int unsigned DST_W      = 32;

    // Extract the destination field, which occupies the top id_w bits of a pkt_w-bit packet.
    // The packet is passed zero-extended to PKT_MAX_W; the result is zero-extended to DST_W.
    function automatic logic [DST_W-1:0] dst_of(input logic [PKT_MAX_W-1:0] pkt,
                                                input int unsigned         pkt_w,
                                                input int unsigned         id_w);
        logic [DST_W-1:0] dst;
        dst = '0;
        for (int unsigned b = 0; b < DST_W; b++) begin
            if (b < id_w) begin
                dst[b] = pkt[PKT_IDX_W'(pkt_w - id_w + b)];
            end
        end
        return dst;
    endfunction

endpackage

// File: rtl/rr_prio_enc.sv
// Rotating priority encoder: picks one requester either round-robin from a
// pointer (searching upward with wrap) or by fixed lowest-index priority.
module rr_prio_enc
    import bus_arb_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned IdxW = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    input  logic            mode_i,
    output logic [IdxW-1:0] gnt_idx_o,
    output logic            valid_o
);

    logic hit;

    // Two-pass search: first requesters at or above the pointer (RR only),
    // then everything from index 0, which realises the wrap-around and also
    // serves as the plain fixed-priority search.
    always_comb begin
        gnt_idx_o = '0;
        hit       = 1'b0;
        if (mode_i == ARB_RR) begin
            for (int i = 0; i < int'(N); i++) begin
                if (!hit && req_i[i] && (IdxW'(i) >= ptr_i)) begin
                    gnt_idx_o = IdxW'(i);
                    hit       = 1'b1;
                end
            end
        end
        for (int i = 0; i < int'(N); i++) begin
            if (!hit && req_i[i]) begin
                gnt_idx_o = IdxW'(i);
                hit       = 1'b1;
            end
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/bus_rr_arbiter_bcast.sv
// Shared-bus arbiter: grants one terminal, pops its head packet, decodes the
// destination and pushes it to one terminal or broadcasts it to all others.
// Destination backpressure is honoured with a bounded stall; packets with an
// invalid destination or that time out are dropped and counted.
module bus_rr_arbiter_bcast
    import bus_arb_pkg::*;
#(
    parameter int unsigned     drvrs     = 4,
    parameter int unsigned     pckg_sz   = 16,
    parameter int unsigned     ID_W      = 8,
    parameter logic [ID_W-1:0] broadcast = {ID_W{1'b1}},
    parameter int unsigned     ARB_MODE  = 0,
    parameter int unsigned     TIMEOUT   = 16,
    parameter int unsigned     CNT_W     = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [drvrs-1:0]           pndng_i,
    input  logic [drvrs*pckg_sz-1:0]   d_pop_i,
    input  logic [drvrs-1:0]           full_i,
    output logic [drvrs-1:0]           pop_o,
    output logic [drvrs-1:0]           push_o,
    output logic [pckg_sz-1:0]         d_push_o,
    output logic [$clog2(drvrs)-1:0]   gnt_id_o,
    output logic                       busy_o,
    output logic [CNT_W-1:0]           drop_cnt_o
);

    localparam int unsigned IdxW    = $clog2(drvrs);
    localparam int unsigned StallW  = $clog2(TIMEOUT + 1);
    localparam logic        ModeSel = (ARB_MODE != 0) ? ARB_FIXED : ARB_RR;

    arb_state_e         state_q, state_d;
    logic [IdxW-1:0]    gnt_q,   gnt_d;
    logic [IdxW-1:0]    ptr_q,   ptr_d;
    logic [pckg_sz-1:0] pkt_q,   pkt_d;
    logic [pckg_sz-1:0] bus_q,   bus_d;
    logic [StallW-1:0]  stall_q, stall_d;
    logic [CNT_W-1:0]   drop_q,  drop_d;

    logic [IdxW-1:0]      win_idx;
    logic                 win_vld;
    logic [pckg_sz-1:0]   head_word;
    logic [PKT_MAX_W-1:0] pkt_ext;
    logic [DST_W-1:0]     dst;
    logic                 dst_uni;
    logic                 dst_bcast;
    logic [drvrs-1:0]     tgt_mask;
    logic [CNT_W-1:0]     drop_inc;
    logic [IdxW-1:0]      win_next;

    rr_prio_enc #(
        .N    (drvrs),
        .IdxW (IdxW)
    ) u_enc (
        .req_i     (pndng_i),
        .ptr_i     (ptr_q),
        .mode_i    (ModeSel),
        .gnt_idx_o (win_idx),
        .valid_o   (win_vld)
    );

    // Head word of the granted terminal, selected with constant slices.
    always_comb begin
        head_word = '0;
        for (int i = 0; i < int'(drvrs); i++) begin
            if (gnt_q == IdxW'(i)) begin
                head_word = d_pop_i[i*pckg_sz +: pckg_sz];
            end
        end
    end

    // Destination decode of the held packet into a target mask.
    always_comb begin
        pkt_ext                = '0;
        pkt_ext[pckg_sz-1:0]   = pkt_q;
        dst                    = dst_of(pkt_ext, pckg_sz, ID_W);
        dst_uni                = (dst < DST_W'(drvrs));
        dst_bcast              = (dst == DST_W'(broadcast));
        tgt_mask               = '0;
        if (dst_uni) begin
            // Self-addressed unicast is a legal loopback.
            tgt_mask[dst[IdxW-1:0]] = 1'b1;
        end else if (dst_bcast) begin
            tgt_mask        = '1;
            tgt_mask[gnt_q] = 1'b0;
        end
    end

    // Helper values: saturating drop increment and RR pointer successor.
    always_comb begin
        drop_inc = (drop_q == '1) ? drop_q : drop_q + 1'b1;
        win_next = (win_idx == IdxW'(drvrs - 1)) ? '0 : win_idx + 1'b1;
    end

    // FSM next-state and strobe generation.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        pkt_d   = pkt_q;
        bus_d   = bus_q;
        stall_d = stall_q;
        drop_d  = drop_q;
        pop_o   = '0;
        push_o  = '0;
        unique case (state_q)
            StIdle: begin
                if (win_vld) begin
                    gnt_d = win_idx;
                    // Pointer advances on every grant, even one later dropped.
                    if (ModeSel == ARB_RR) begin
                        ptr_d = win_next;
                    end
                    state_d = StPop;
                end
            end
            StPop: begin
                if (pndng_i[gnt_q]) begin
                    pop_o[gnt_q] = 1'b1;
                    pkt_d        = head_word;
                    stall_d      = '0;
                    state_d      = StDeliver;
                end else begin
                    // Requester withdrew between grant and pop.
                    state_d = StIdle;
                end
            end
            StDeliver: begin
                if (!dst_uni && !dst_bcast) begin
                    drop_d  = drop_inc;
                    state_d = StIdle;
                end else if ((tgt_mask & full_i) == '0) begin
                    // All targets ready in the same cycle; broadcast is all-or-nothing.
                    push_o  = tgt_mask;
                    bus_d   = pkt_q;
                    state_d = StIdle;
                end else if (stall_q == StallW'(TIMEOUT - 1)) begin
                    // This is the TIMEOUT-th stalled cycle: give up on the packet.
                    drop_d  = drop_inc;
                    state_d = StIdle;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            ptr_q   <= '0;
            pkt_q   <= '0;
            bus_q   <= '0;
            stall_q <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            pkt_q   <= pkt_d;
            bus_q   <= bus_d;
            stall_q <= stall_d;
            drop_q  <= drop_d;
        end
    end

    // Bus data shows the packet during a push and holds the last pushed word otherwise.
    always_comb begin
        d_push_o   = (push_o != '0) ? pkt_q : bus_q;
        gnt_id_o   = gnt_q;
        busy_o     = (state_q != StIdle);
        drop_cnt_o = drop_q;
    end

endmodule

// File: tb/tb_bus_rr_arbiter_bcast.sv
// Directed testbench for bus_rr_arbiter_bcast (round-robin and fixed-priority instances).
module tb_bus_rr_arbiter_bcast;

    logic        clk;
    logic        rst_n;
    logic [3:0]  pndng;
    logic [63:0] d_pop;
    logic [3:0]  full;

    logic [3:0]  rr_pop, rr_push, fx_pop, fx_push;
    logic [15:0] rr_dpush, fx_dpush;
    logic [1:0]  rr_gnt, fx_gnt;
    logic        rr_busy, fx_busy;
    logic [7:0]  rr_drop, fx_drop;

    int total = 0;
    int bad   = 0;

    bus_rr_arbiter_bcast #(.ARB_MODE(0)) dut_rr (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .pndng_i    (pndng),
        .d_pop_i    (d_pop),
        .full_i     (full),
        .pop_o      (rr_pop),
        .push_o     (rr_push),
        .d_push_o   (rr_dpush),
        .gnt_id_o   (rr_gnt),
        .busy_o     (rr_busy),
        .drop_cnt_o (rr_drop)
    );

    bus_rr_arbiter_bcast #(.ARB_MODE(1)) dut_fx (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .pndng_i    (pndng),
        .d_pop_i    (d_pop),
        .full_i     (full),
        .pop_o      (fx_pop),
        .push_o     (fx_push),
        .d_push_o   (fx_dpush),
        .gnt_id_o   (fx_gnt),
        .busy_o     (fx_busy),
        .drop_cnt_o (fx_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        pndng = 4'h0;
        full  = 4'h0;
        d_pop = {4{16'h0201}};
        #2;
        rst_n = 1'b0;
        pndng = 4'hF;
        repeat (3) cyc();
        total++; if (rr_pop !== 4'h0) begin bad++; $display("FAIL rst_pop got=%h want=%h", rr_pop, 4'h0); end
        total++; if (rr_push !== 4'h0) begin bad++; $display("FAIL rst_push got=%h want=%h", rr_push, 4'h0); end
        total++; if (rr_dpush !== 16'h0) begin bad++; $display("FAIL rst_dpush got=%h want=%h", rr_dpush, 16'h0); end
        total++; if (rr_drop !== 8'h0) begin bad++; $display("FAIL rst_drop got=%h want=%h", rr_drop, 8'h0); end
        total++; if (rr_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", rr_busy); end
        total++; if (rr_gnt !== 2'd0) begin bad++; $display("FAIL rst_gnt got=%0d want=0", rr_gnt); end
        // Reset while a packet is being delivered.
        pndng = 4'b0001;
        rst_n = 1'b1;
        cyc();
        cyc();
        pndng = 4'b0000;
        #1;
        total++; if (rr_push !== 4'b0100) begin bad++; $display("FAIL rst_pre_push got=%b want=0100", rr_push); end
        rst_n = 1'b0;
        #1;
        total++; if (rr_push !== 4'b0000) begin bad++; $display("FAIL rst_mid_push got=%b want=0000", rr_push); end
        total++; if (rr_busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b want=0", rr_busy); end
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_unicast();
        d_pop = {16'h0000, 16'h0000, 16'h0000, 16'h0201};
        pndng = 4'b0001;
        cyc();
        total++; if (rr_pop !== 4'b0001) begin bad++; $display("FAIL uni_pop got=%b want=0001", rr_pop); end
        total++; if (rr_push !== 4'b0000) begin bad++; $display("FAIL uni_nopush got=%b want=0000", rr_push); end
        total++; if (rr_busy !== 1'b1) begin bad++; $display("FAIL uni_busy got=%b want=1", rr_busy); end
        cyc();
        pndng = 4'b0000;
        #1;
        total++; if (rr_push !== 4'b0100) begin bad++; $display("FAIL uni_push got=%b want=0100", rr_push); end
        total++; if (rr_dpush !== 16'h0201) begin bad++; $display("FAIL uni_dpush got=%h want=0201", rr_dpush); end
        total++; if (rr_pop !== 4'b0000) begin bad++; $display("FAIL uni_nopop got=%b want=0000", rr_pop); end
        cyc();
        total++; if (rr_busy !== 1'b0) begin bad++; $display("FAIL uni_idle got=%b want=0", rr_busy); end
        total++; if (rr_dpush !== 16'h0201) begin bad++; $display("FAIL uni_hold got=%h want=0201", rr_dpush); end
    endtask

    task automatic test_arbitration();
        logic [1:0] rr_exp [5];
        logic [3:0] pop_exp;
        rr_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        d_pop = {4{16'h0100}};
        pndng = 4'hF;
        for (int k = 0; k < 5; k++) begin
            cyc();
            pop_exp = 4'b0001 << rr_exp[k];
            total++; if (rr_gnt !== rr_exp[k]) begin bad++; $display("FAIL arb_rr_gnt[%0d] got=%0d want=%0d", k, rr_gnt, rr_exp[k]); end
            total++; if (rr_pop !== pop_exp) begin bad++; $display("FAIL arb_rr_pop[%0d] got=%b want=%b", k, rr_pop, pop_exp); end
            total++; if (fx_gnt !== 2'd0) begin bad++; $display("FAIL arb_fx_gnt[%0d] got=%0d want=0", k, fx_gnt); end
            cyc();
            total++; if (rr_push !== 4'b0010) begin bad++; $display("FAIL arb_rr_push[%0d] got=%b want=0010", k, rr_push); end
            total++; if (fx_push !== 4'b0010) begin bad++; $display("FAIL arb_fx_push[%0d] got=%b want=0010", k, fx_push); end
            cyc();
        end
        pndng = 4'h0;
    endtask

    task automatic test_broadcast();
        d_pop = {16'h0000, 16'hFF55, 16'h0000, 16'h0000};
        pndng = 4'b0100;
        cyc();
        total++; if (rr_pop !== 4'b0100) begin bad++; $display("FAIL bc_pop got=%b want=0100", rr_pop); end
        total++; if (rr_gnt !== 2'd2) begin bad++; $display("FAIL bc_gnt got=%0d want=2", rr_gnt); end
        cyc();
        pndng = 4'b0000;
        #1;
        total++; if (rr_push !== 4'b1011) begin bad++; $display("FAIL bc_push got=%b want=1011", rr_push); end
        total++; if (rr_dpush !== 16'hFF55) begin bad++; $display("FAIL bc_dpush got=%h want=ff55", rr_dpush); end
        cyc();
        // Same source again, with terminal 0 full for the first three DELIVER cycles.
        d_pop = {16'h0000, 16'hFFAA, 16'h0000, 16'h0000};
        pndng = 4'b0100;
        cyc();
        full = 4'b0001;
        #1;
        total++; if (rr_pop !== 4'b0100) begin bad++; $display("FAIL bc2_pop got=%b want=0100", rr_pop); end
        for (int s = 0; s < 3; s++) begin
            cyc();
            pndng = 4'b0000;
            #1;
            total++; if (rr_push !== 4'b0000) begin bad++; $display("FAIL bc2_stall[%0d] got=%b want=0000", s, rr_push); end
            total++; if (rr_dpush !== 16'hFF55) begin bad++; $display("FAIL bc2_hold[%0d] got=%h want=ff55", s, rr_dpush); end
        end
        cyc();
        full = 4'b0000;
        #1;
        total++; if (rr_push !== 4'b1011) begin bad++; $display("FAIL bc2_push got=%b want=1011", rr_push); end
        total++; if (rr_dpush !== 16'hFFAA) begin bad++; $display("FAIL bc2_dpush got=%h want=ffaa", rr_dpush); end
        cyc();
    endtask

    task automatic test_timeout();
        d_pop = {16'h0000, 16'h0000, 16'h0377, 16'h0312};
        pndng = 4'b0010;
        full  = 4'b1000;
        cyc();
        total++; if (rr_pop !== 4'b0010) begin bad++; $display("FAIL to_pop got=%b want=0010", rr_pop); end
        cyc();
        pndng = 4'b0000;
        #1;
        for (int i = 0; i < 16; i++) begin
            total++; if (rr_push !== 4'b0000 || rr_busy !== 1'b1 || rr_drop !== 8'd0) begin
                bad++;
                $display("FAIL to_stall[%0d] got push=%b busy=%b drop=%0d want push=0000 busy=1 drop=0",
                         i, rr_push, rr_busy, rr_drop);
            end
            cyc();
        end
        total++; if (rr_busy !== 1'b0) begin bad++; $display("FAIL to_idle got=%b want=0", rr_busy); end
        total++; if (rr_drop !== 8'd1) begin bad++; $display("FAIL to_drop got=%0d want=1", rr_drop); end
        // Next packet is served normally.
        full  = 4'b0000;
        pndng = 4'b0001;
        cyc();
        total++; if (rr_pop !== 4'b0001) begin bad++; $display("FAIL to_next_pop got=%b want=0001", rr_pop); end
        cyc();
        pndng = 4'b0000;
        #1;
        total++; if (rr_push !== 4'b1000) begin bad++; $display("FAIL to_next_push got=%b want=1000", rr_push); end
        total++; if (rr_dpush !== 16'h0312) begin bad++; $display("FAIL to_next_dpush got=%h want=0312", rr_dpush); end
        cyc();
    endtask

    task automatic test_invalid();
        d_pop = {16'h0000, 16'h0000, 16'h0000, 16'h0700};
        pndng = 4'b0001;
        cyc();
        total++; if (rr_pop !== 4'b0001) begin bad++; $display("FAIL inv_pop got=%b want=0001", rr_pop); end
        cyc();
        pndng = 4'b0000;
        #1;
        total++; if (rr_push !== 4'b0000) begin bad++; $display("FAIL inv_push got=%b want=0000", rr_push); end
        cyc();
        total++; if (rr_drop !== 8'd2) begin bad++; $display("FAIL inv_drop got=%0d want=2", rr_drop); end
        total++; if (rr_busy !== 1'b0) begin bad++; $display("FAIL inv_idle got=%b want=0", rr_busy); end
        // Saturation: keep feeding invalid packets, one drop every three cycles.
        pndng = 4'b0001;
        repeat (252 * 3) cyc();
        total++; if (rr_drop !== 8'd254) begin bad++; $display("FAIL sat_pre got=%0d want=254", rr_drop); end
        repeat (5 * 3) cyc();
        pndng = 4'b0000;
        cyc();
        total++; if (rr_drop !== 8'hFF) begin bad++; $display("FAIL sat_hold got=%h want=ff", rr_drop); end
    endtask

    initial begin
        test_reset();
        test_unicast();
        test_arbitration();
        test_broadcast();
        test_timeout();
        test_invalid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bus_rr_arbiter_bcast.md
Name: bus_rr_arbiter_bcast

Overview:
- Next-generation shared-bus generator/arbiter for `drvrs` terminals.
- Each terminal exposes a pending flag and a head-of-FIFO word. The block grants one terminal at a time, pops its packet, decodes the destination and pushes the packet to one terminal or broadcasts it to all others.
- New versus the previous arbiter:
  - selectable round-robin or fixed priority;
  - per-destination backpressure (`full`) with a stall timeout;
  - drop accounting for invalid destinations and timeouts.
- Sits between the terminal FIFOs and the bus interface used by the driver/monitor bench.

Parameters:
- drvrs, 4, number of terminals (2..16).
- pckg_sz, 16, packet width in bits; must be > ID_W.
- ID_W, 8, destination field width; field is packet bits [pckg_sz-1 -: ID_W].
- broadcast, {ID_W{1'b1}}, destination value meaning "all terminals except source".
- ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (lowest index wins).
- TIMEOUT, 16, maximum DELIVER stall cycles before the packet is dropped.
- CNT_W, 8, drop counter width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- pndng  in  drvrs  terminal i has a packet waiting.
- D_pop  in  drvrs*pckg_sz  head word of terminal i, slice [i*pckg_sz +: pckg_sz].
- full  in  drvrs  terminal i cannot accept a push this cycle.
- pop  out  drvrs  one-cycle pulse consuming terminal i's head.
- push  out  drvrs  one-cycle write strobe to terminal i.
- D_push  out  pckg_sz  shared bus data, valid while any push bit is set.
- gnt_id  out  $clog2(drvrs)  currently/last granted terminal.
- busy  out  1  high in any state other than IDLE.
- drop_cnt  out  CNT_W  saturating count of dropped packets.

Behaviour:
- Reset (reset=0, takes effect immediately, no clock edge needed):
  - outputs: pop=0, push=0, D_push=0, gnt_id=0, busy=0, drop_cnt=0;
  - internals: state=IDLE, RR pointer=0, stall counter=0;
  - any in-flight packet is lost.
- FSM states:
  - IDLE: if |pndng, register the winner into gnt_id and go to POP; else stay.
  - POP: if pndng[gnt_id]=1, assert pop[gnt_id] for exactly this cycle and latch D_pop slice into pkt_q at the closing edge, then go to DELIVER. If pndng[gnt_id] has dropped, no pop; return to IDLE.
  - DELIVER: decode pkt_q destination field `dst`:
    - dst < drvrs: target mask = one-hot(dst). Self-addressed packets are delivered (loopback).
    - dst == broadcast: target mask = all ones except bit gnt_id.
    - otherwise invalid: no push, drop_cnt++ (saturating), go to IDLE.
  - DELIVER, valid destination:
    - if (mask & full)==0: push=mask for one cycle, D_push=pkt_q, go to IDLE;
    - else stall, stall counter++;
    - when the counter reaches TIMEOUT: drop, drop_cnt++, go to IDLE.
  - Broadcast is all-or-nothing: every target must be not-full in the same cycle.
- Arbitration:
  - Round-robin searches upward from ptr with wrap. ptr becomes winner+1 (mod drvrs) on each grant, including grants later dropped.
  - Fixed priority: lowest set index of pndng. ptr is unused.
- Latency and throughput:
  - pndng high in IDLE at cycle N → pop at N+1 → push at N+2 (no stall).
  - Minimum 3 cycles per packet.
- Data rules:
  - D_push holds its last value between pushes.
  - push and pop are never asserted in the same cycle.
  - full is ignored outside DELIVER.
  - The stall counter clears on entry to DELIVER.
  - drop_cnt saturates at all ones.

Decomposition:
- Package bus_arb_pkg:
  - state enum {IDLE, POP, DELIVER};
  - ARB_RR/ARB_FIXED constants;
  - function dst_of(pkt) extracting the ID field.
- Sub-module rr_prio_enc:
  - parametrised rotating priority encoder (req, ptr, mode → grant index, valid);
  - purely combinational, reused by later multi-bus versions.
- Top holds the FSM, pkt_q, counters and decode.

Test Plan:
1. Reset: hold reset=0 with pndng=4'hF → pop=0, push=0, D_push=0, drop_cnt=0. Assert reset=0 mid-DELIVER → push drops to 0 immediately, busy=0.
2. Unicast: pndng=4'b0001, D_pop[0]=16'h0201 → pop=4'b0001 at N+1; push=4'b0100, D_push=16'h0201 at N+2; busy low at N+3.
3. Arbitration: pndng=4'hF held, all dst=1 → RR grant order 0,1,2,3,0. Same stimulus with ARB_MODE=1 → grant 0 every time.
4. Broadcast: terminal 2 sends 16'hFF55 → push=4'b1011, D_push=16'hFF55. With full[0]=1 for 3 cycles → push delayed exactly 3 cycles.
5. Timeout: dst=3, full[3]=1 held → no push, drop_cnt 0→1 after 16 stall cycles, return to IDLE. Next packet is served normally.
6. Invalid destination: D_pop=16'h0700 with drvrs=4 → pop pulsed, no push, drop_cnt+1. Force drop_cnt to 8'hFF and repeat → stays at 8'hFF.
